// File: rtl/regfile_branch_unit_if.sv
// Decode-side bundle for the integer register file and branch comparator.
// The writeback/decode logic drives it as master; the register file is the slave.
interface regfile_branch_unit_if #(
   parameter int XLEN    = 32,
   parameter int ADDR_W  = 5,
   parameter int BR_OP_W = 3
);
   logic [ADDR_W-1:0]  rs1_addr;
   logic [ADDR_W-1:0]  rs2_addr;
   logic [XLEN-1:0]    rs1_data;
   logic [XLEN-1:0]    rs2_data;
   logic [ADDR_W-1:0]  rd_addr;
   logic [XLEN-1:0]    rd_data;
   logic               reg_write_en;
   logic [BR_OP_W-1:0] br_op;
   logic               br_true;

   modport master (
      output rs1_addr, rs2_addr, rd_addr, rd_data, reg_write_en, br_op,
      input  rs1_data, rs2_data, br_true
   );

   modport slave (
      input  rs1_addr, rs2_addr, rd_addr, rd_data, reg_write_en, br_op,
      output rs1_data, rs2_data, br_true
   );
endinterface

// File: rtl/regfile_branch_unit.sv
// RV32I integer register file (2 combinational reads, 1 synchronous write with
// write-first bypass) and the branch condition comparator on the read values.
module regfile_branch_unit #(
   parameter int XLEN    = 32,
   parameter int NREGS   = 32,
   parameter int ADDR_W  = 5,
   parameter int BR_OP_W = 3
) (
   input logic                 clk,
   input logic                 rst_n,
   regfile_branch_unit_if.slave bus
);

   localparam logic [BR_OP_W-1:0] OP_BEQ  = BR_OP_W'(3'b000);
   localparam logic [BR_OP_W-1:0] OP_BNE  = BR_OP_W'(3'b001);
   localparam logic [BR_OP_W-1:0] OP_BLT  = BR_OP_W'(3'b100);
   localparam logic [BR_OP_W-1:0] OP_BGE  = BR_OP_W'(3'b101);
   localparam logic [BR_OP_W-1:0] OP_BLTU = BR_OP_W'(3'b110);
   localparam logic [BR_OP_W-1:0] OP_BGEU = BR_OP_W'(3'b111);

   logic [XLEN-1:0] regs [NREGS];
   logic [XLEN-1:0] rs1_stored;
   logic [XLEN-1:0] rs2_stored;
   logic            bypass_ok;
   logic            wr_fire;

   // x0 is a hardwired zero; addresses beyond NREGS read as zero.
   function automatic logic [XLEN-1:0] port_value(
      input logic [ADDR_W-1:0] addr,
      input logic [XLEN-1:0]   stored,
      input logic              bypass,
      input logic [ADDR_W-1:0] waddr,
      input logic [XLEN-1:0]   wdata
   );
      logic [XLEN-1:0] value;
      if (addr == '0)
         value = '0;
      else if (bypass && (waddr == addr))
         value = wdata;
      else
         value = stored;
      return value;
   endfunction

   function automatic logic branch_eval(
      input logic [BR_OP_W-1:0] op,
      input logic [XLEN-1:0]    a,
      input logic [XLEN-1:0]    b
   );
      logic signed [XLEN-1:0] sa;
      logic signed [XLEN-1:0] sb;
      logic                   taken;
      sa = a;
      sb = b;
      case (op)
         OP_BEQ:  taken = (a == b);
         OP_BNE:  taken = (a != b);
         OP_BLT:  taken = (sa < sb);
         OP_BGE:  taken = (sa >= sb);
         OP_BLTU: taken = (a < b);
         OP_BGEU: taken = (a >= b);
         default: taken = 1'b0;
      endcase
      return taken;
   endfunction

   assign bypass_ok = rst_n && bus.reg_write_en;
   assign wr_fire   = bus.reg_write_en && (bus.rd_addr != '0) &&
                      (int'(bus.rd_addr) < NREGS);

   always_comb begin
      rs1_stored = '0;
      if (int'(bus.rs1_addr) < NREGS)
         rs1_stored = regs[bus.rs1_addr];
   end

   always_comb begin
      rs2_stored = '0;
      if (int'(bus.rs2_addr) < NREGS)
         rs2_stored = regs[bus.rs2_addr];
   end

   assign bus.rs1_data = port_value(bus.rs1_addr, rs1_stored, bypass_ok,
                                    bus.rd_addr, bus.rd_data);
   assign bus.rs2_data = port_value(bus.rs2_addr, rs2_stored, bypass_ok,
                                    bus.rd_addr, bus.rd_data);

   // Compare on post-bypass operands so decode resolves against fresh values.
   assign bus.br_true = branch_eval(bus.br_op, bus.rs1_data, bus.rs2_data);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++)
            regs[i] <= '0;
      end else if (wr_fire) begin
         regs[bus.rd_addr] <= bus.rd_data;
      end
   end

endmodule

// File: tb/tb_regfile_branch_unit.sv
// Randomized bench for regfile_branch_unit with an array-based reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_regfile_branch_unit;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;
   bit   chk_on;
   logic [31:0] mregs [32];

   regfile_branch_unit_if bus ();

   regfile_branch_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_read(input logic [4:0] addr);
      if (addr == 5'd0) return 32'h0;
      if (rst_n && bus.reg_write_en && bus.rd_addr == addr) return bus.rd_data;
      return mregs[addr];
   endfunction

   function automatic logic m_br(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic slt;
      slt = (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
      case (op)
         3'd0: return a == b;
         3'd1: return a != b;
         3'd4: return slt;
         3'd5: return !slt;
         3'd6: return a < b;
         3'd7: return !(a < b);
         default: return 1'b0;
      endcase
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) mregs[i] <= 32'h0;
      end else if (bus.reg_write_en && bus.rd_addr != 5'd0) begin
         mregs[bus.rd_addr] <= bus.rd_data;
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         logic [31:0] e1, e2;
         e1 = m_read(bus.rs1_addr);
         e2 = m_read(bus.rs2_addr);
         chk("model_rs1", bus.rs1_data, e1);
         chk("model_rs2", bus.rs2_data, e2);
         chk("model_br", {31'b0, bus.br_true}, {31'b0, m_br(bus.br_op, e1, e2)});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic en, input logic [4:0] rd, input logic [31:0] d,
                        input logic [4:0] a1, input logic [4:0] a2, input logic [2:0] op);
      bus.reg_write_en = en;
      bus.rd_addr      = rd;
      bus.rd_data      = d;
      bus.rs1_addr     = a1;
      bus.rs2_addr     = a2;
      bus.br_op        = op;
      #1;
   endtask

   task automatic br_expect(input string name, input logic [2:0] op, input logic exp);
      bus.br_op = op;
      #1;
      chk(name, {31'b0, bus.br_true}, {31'b0, exp});
   endtask

   function automatic logic [31:0] rand_data();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'h7FFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      errors = 0;
      checks = 0;
      chk_on = 1'b0;
      rst_n  = 1'b0;
      drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 3'd0);
      tick();
      tick();
      rst_n  = 1'b1;
      chk_on = 1'b1;
      chk("reset_x1", bus.rs1_data, 32'h0);

      // Reset clears a written register and suppresses bypass/writes while low
      drive(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd0, 3'd0);
      tick();
      drive(1'b0, 5'd5, 32'h0, 5'd5, 5'd0, 3'd0);
      chk("pre_reset_x5", bus.rs1_data, 32'hDEAD_BEEF);
      rst_n = 1'b0;
      tick();
      tick();
      chk("reset_x5", bus.rs1_data, 32'h0);
      drive(1'b1, 5'd5, 32'h1234_0000, 5'd5, 5'd5, 3'd0);
      chk("reset_no_bypass", bus.rs1_data, 32'h0);
      tick();
      chk("reset_no_write", bus.rs2_data, 32'h0);
      rst_n = 1'b1;

      // Write then read on both ports; disabled write holds state
      drive(1'b1, 5'd7, 32'h1234_5678, 5'd0, 5'd0, 3'd0);
      tick();
      drive(1'b0, 5'd7, 32'hFFFF_FFFF, 5'd7, 5'd7, 3'd0);
      chk("wr_rs1_x7", bus.rs1_data, 32'h1234_5678);
      chk("wr_rs2_x7", bus.rs2_data, 32'h1234_5678);
      tick();
      chk("hold_x7", bus.rs1_data, 32'h1234_5678);

      // x0 is never written nor bypassed
      drive(1'b1, 5'd0, 32'hAAAA_AAAA, 5'd0, 5'd0, 3'd0);
      chk("x0_bypass", bus.rs1_data, 32'h0);
      tick();
      chk("x0_after", bus.rs1_data, 32'h0);

      // Write-first bypass
      drive(1'b1, 5'd3, 32'h1, 5'd0, 5'd3, 3'd0);
      tick();
      drive(1'b1, 5'd3, 32'h55, 5'd0, 5'd3, 3'd0);
      chk("bypass_before", bus.rs2_data, 32'h55);
      tick();
      drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd3, 3'd0);
      chk("bypass_after", bus.rs2_data, 32'h55);

      // Signed vs unsigned compares
      drive(1'b1, 5'd1, 32'hFFFF_FFFF, 5'd0, 5'd0, 3'd0);
      tick();
      drive(1'b1, 5'd2, 32'h0000_0001, 5'd0, 5'd0, 3'd0);
      tick();
      drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd2, 3'd0);
      br_expect("blt_m1_1", 3'd4, 1'b1);
      br_expect("bltu_m1_1", 3'd6, 1'b0);
      br_expect("bge_m1_1", 3'd5, 1'b0);
      br_expect("bgeu_m1_1", 3'd7, 1'b1);
      br_expect("beq_m1_1", 3'd0, 1'b0);
      br_expect("bne_m1_1", 3'd1, 1'b1);
      br_expect("rsv010", 3'd2, 1'b0);
      br_expect("rsv011", 3'd3, 1'b0);
      bus.rs2_addr = 5'd1;
      br_expect("beq_same", 3'd0, 1'b1);
      br_expect("bge_same", 3'd5, 1'b1);
      br_expect("bgeu_same", 3'd7, 1'b1);
      br_expect("blt_same", 3'd4, 1'b0);
      br_expect("rsv011_same", 3'd3, 1'b0);

      // Boundary pair: most negative vs most positive
      drive(1'b1, 5'd1, 32'h8000_0000, 5'd0, 5'd0, 3'd0);
      tick();
      drive(1'b1, 5'd2, 32'h7FFF_FFFF, 5'd0, 5'd0, 3'd0);
      tick();
      drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd2, 3'd0);
      br_expect("blt_boundary", 3'd4, 1'b1);
      br_expect("bltu_boundary", 3'd6, 1'b0);
      br_expect("rsv010_boundary", 3'd2, 1'b0);

      // Random traffic against the reference model
      for (int n = 0; n < 600; n++) begin
         logic [4:0] rd;
         rd = 5'($urandom_range(0, 31));
         rst_n = ($urandom_range(0, 31) != 0);
         drive(1'($urandom_range(0, 1)), rd, rand_data(),
               ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31)),
               ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31)),
               3'($urandom_range(0, 7)));
         tick();
      end
      rst_n = 1'b1;
      tick();

      chk_on = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/regfile_branch_unit.md
Name: regfile_branch_unit

Overview:
- Integer register file plus branch comparator for the RV32I decode stage.
- Provides two combinational read ports and one synchronous write port, fed by writeback.
- A combinational comparator evaluates the branch condition on the two read-port values.
- br_true feeds the branch-resolution logic in decode.

Parameters:
XLEN, 32, data width of registers and compare operands
NREGS, 32, number of architectural registers
ADDR_W, 5, register address width (log2 NREGS)
BR_OP_W, 3, branch-op select width (matches funct3)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
rs1_addr  input  ADDR_W  read port 1 address
rs2_addr  input  ADDR_W  read port 2 address
rs1_data  output  XLEN  read port 1 data (combinational)
rs2_data  output  XLEN  read port 2 data (combinational)
rd_addr  input  ADDR_W  write address
rd_data  input  XLEN  write data
reg_write_en  input  1  write enable
br_op  input  BR_OP_W  branch condition select
br_true  output  1  branch condition result (combinational)

Behaviour:
Interface: one clock; reset is synchronous and active-low.

Reset:
- On a rising clk edge with rst_n=0, all NREGS registers clear to 0.
- Writes are ignored in that cycle.
- While rst_n=0, the write bypass is disabled, so reads return stored contents, normally 0.

Writes:
- On a rising edge with rst_n=1 and reg_write_en=1 and rd_addr!=0, regs[rd_addr] <= rd_data.
- Writes to address 0 are discarded.
- With reg_write_en=0, state holds.

Register x0:
- Always reads 0, regardless of writes or bypass.

Reads:
- Purely combinational, zero latency.
- rsN_data = 0 if rsN_addr==0.
- Else rd_data if rst_n=1, reg_write_en=1 and rd_addr==rsN_addr (write-first bypass).
- Else regs[rsN_addr].
- The bypass lets an instruction in decode see the value being written back in the same cycle.
- Both ports are independent and may read the same address.

Branch compare (combinational on a=rs1_data, b=rs2_data, post-bypass values):
- 000 BEQ: a==b
- 001 BNE: a!=b
- 100 BLT: signed a<b
- 101 BGE: signed a>=b
- 110 BLTU: unsigned a<b
- 111 BGEU: unsigned a>=b
- 010, 011: br_true=0

Other rules:
- Signed compares use two's complement XLEN bits; no truncation or extension.
- br_true has no reset value of its own; it follows its inputs at all times, including during reset.
- No X propagation: every br_op value drives a defined output.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles after writing x5=0xDEADBEEF -> rs1_addr=5 reads 0x00000000.
2. Write/read: write x7=0x12345678 with reg_write_en=1 -> next cycle rs1_addr=7 and rs2_addr=7 both read 0x12345678. Then write x7=0xFFFFFFFF with reg_write_en=0 -> x7 still 0x12345678.
3. x0: write rd_addr=0, rd_data=0xAAAAAAAA -> same cycle (bypass) and next cycle rs1_addr=0 reads 0.
4. Bypass: x3 holds 0x1, drive rd_addr=3, rd_data=0x55, reg_write_en=1 -> rs2_data=0x55 before the edge, and remains 0x55 after the edge.
5. Signed vs unsigned: x1=0xFFFFFFFF, x2=0x00000001 ->
   - BLT=1, BLTU=0, BGE=0, BGEU=1, BEQ=0, BNE=1.
   - Same register on both ports: BEQ=1, BGE=1, BGEU=1, BLT=0.
6. Reserved ops: br_op=010 and 011 with any operands -> br_true=0.
   Boundary pair x1=0x80000000, x2=0x7FFFFFFF -> BLT=1, BLTU=0.
